// File: rtl/sha256_padder.sv
// SHA-256 message padder: appends 0x80, zero fill and the 64-bit bit length, one registered output word per cycle.
// Optional sticky length-overflow flag (len_ovf_o) is built when SHA256_PAD_OVF_EN is defined.
module sha256_padder #(
  parameter int LEN_W = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_data_i,
  input  logic        in_last_i,
  input  logic [2:0]  in_bytes_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_word_o,
  output logic [3:0]  out_idx_o,
  output logic        out_msg_end_o,
`ifdef SHA256_PAD_OVF_EN
  output logic        len_ovf_o,
`endif
  output logic [2:0]  dbg_state_o
);

  // Handshake: a word moves on a rising edge where valid && ready are both high;
  // the sender keeps data stable while valid && !ready.
  localparam logic [2:0] DATA   = 3'd0;
  localparam logic [2:0] PAD80  = 3'd1;
  localparam logic [2:0] ZERO   = 3'd2;
  localparam logic [2:0] LEN_HI = 3'd3;
  localparam logic [2:0] LEN_LO = 3'd4;

  logic [2:0]       state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_word_q, out_word_d;
  logic [3:0]       out_idx_q, out_idx_d;
  logic             out_msg_end_q, out_msg_end_d;
  logic [3:0]       widx_q, widx_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;

  logic             out_free;
  logic             in_ready;
  logic             accept;
  logic [2:0]       nbytes;
  logic [LEN_W-1:0] add_w;
  logic [63:0]      len64;
  logic             produce;
  logic [31:0]      word;
  logic             msg_end;
  logic [31:0]      last_word;
  logic [2:0]       after_pad;

  always_comb begin
    out_free = !out_valid_q || out_ready_i;
    in_ready = (state_q == DATA) && out_free;
    accept   = in_valid_i && in_ready;
    nbytes   = (in_bytes_i > 3'd4) ? 3'd4 : in_bytes_i;
    add_w    = '0;
    add_w[5:0] = in_last_i ? {nbytes, 3'b000} : 6'd32;
    len64    = '0;
    len64[LEN_W-1:0] = cnt_q;
    // The 0x80 word at idx 13 leaves room for the length; anything later spills into a new block.
    after_pad = (widx_q == 4'd13) ? LEN_HI : ZERO;
    case (nbytes)
      3'd0:    last_word = 32'h8000_0000;
      3'd1:    last_word = {in_data_i[31:24], 24'h80_0000};
      3'd2:    last_word = {in_data_i[31:16], 16'h8000};
      default: last_word = {in_data_i[31:8], 8'h80};
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    widx_d        = widx_q;
    out_valid_d   = out_valid_q && !out_ready_i;
    out_word_d    = out_word_q;
    out_idx_d     = out_idx_q;
    out_msg_end_d = out_msg_end_q;
    produce       = 1'b0;
    word          = 32'h0;
    msg_end       = 1'b0;
    if (out_free) begin
      case (state_q)
        DATA: begin
          if (accept) begin
            produce = 1'b1;
            cnt_d   = cnt_q + add_w;
            if (!in_last_i || nbytes == 3'd4) begin
              word = in_data_i;
              if (in_last_i) state_d = PAD80;
            end else begin
              word    = last_word;
              state_d = after_pad;
            end
          end
        end
        PAD80: begin
          produce = 1'b1;
          word    = 32'h8000_0000;
          state_d = after_pad;
        end
        ZERO: begin
          produce = 1'b1;
          state_d = after_pad;
        end
        LEN_HI: begin
          produce = 1'b1;
          word    = len64[63:32];
          state_d = LEN_LO;
        end
        LEN_LO: begin
          produce = 1'b1;
          word    = len64[31:0];
          msg_end = 1'b1;
          cnt_d   = '0;
          state_d = DATA;
        end
        default: state_d = DATA;
      endcase
    end
    if (produce) begin
      out_valid_d   = 1'b1;
      out_word_d    = word;
      out_idx_d     = widx_q;
      out_msg_end_d = msg_end;
      widx_d        = widx_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= DATA;
      out_valid_q   <= 1'b0;
      out_word_q    <= 32'h0;
      out_idx_q     <= 4'd0;
      out_msg_end_q <= 1'b0;
      widx_q        <= 4'd0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      out_valid_q   <= out_valid_d;
      out_word_q    <= out_word_d;
      out_idx_q     <= out_idx_d;
      out_msg_end_q <= out_msg_end_d;
      widx_q        <= widx_d;
      cnt_q         <= cnt_d;
    end
  end

`ifdef SHA256_PAD_OVF_EN
  logic [LEN_W:0] sum_ext;
  logic           ovf_q, ovf_d;
  logic           first_q, first_d;

  // first_q marks that the next accepted word opens a new message, which clears the flag.
  always_comb begin
    sum_ext = {1'b0, cnt_q} + {1'b0, add_w};
    ovf_d   = ovf_q;
    first_d = first_q;
    if (accept) begin
      ovf_d   = (first_q ? 1'b0 : ovf_q) | sum_ext[LEN_W];
      first_d = in_last_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q   <= 1'b0;
      first_q <= 1'b1;
    end else begin
      ovf_q   <= ovf_d;
      first_q <= first_d;
    end
  end

  assign len_ovf_o = ovf_q;
`endif

  assign in_ready_o    = in_ready;
  assign out_valid_o   = out_valid_q;
  assign out_word_o    = out_word_q;
  assign out_idx_o     = out_idx_q;
  assign out_msg_end_o = out_msg_end_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_sha256_padder.sv
// Directed bench for sha256_padder: a byte-level padding model fills the expected queue,
// the output monitor pops and compares every transferred word.
module tb_sha256_padder;
`ifdef SHA256_PAD_OVF_EN
  localparam int LW = 16;
`else
  localparam int LW = 32;
`endif

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic [2:0]  in_bytes;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [3:0]  out_idx;
  logic        out_msg_end;
  logic [2:0]  dbg_state;
`ifdef SHA256_PAD_OVF_EN
  logic        len_ovf;
`endif

  sha256_padder #(.LEN_W(LW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_data_i    (in_data),
    .in_last_i    (in_last),
    .in_bytes_i   (in_bytes),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_word_o   (out_word),
    .out_idx_o    (out_idx),
    .out_msg_end_o(out_msg_end),
`ifdef SHA256_PAD_OVF_EN
    .len_ovf_o    (len_ovf),
`endif
    .dbg_state_o  (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk;
  int          n_fail;
  logic [36:0] exp_q[$];
  bit          force_stall;
  bit          rand_bp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference padding done on bytes: msg, 0x80, zeros to 56 mod 64, 64-bit big-endian bit length.
  task automatic build_exp(input logic [7:0] m[$]);
    logic [7:0]  p[$];
    logic [63:0] bits;
    int          nw;
    p = m;
    bits = 64'(m.size()) * 64'd8;
    if (LW < 64) bits = bits & ((64'd1 << LW) - 64'd1);
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int b = 7; b >= 0; b--) p.push_back(bits[8*b +: 8]);
    nw = p.size() / 4;
    for (int k = 0; k < nw; k++)
      exp_q.push_back({(k == nw - 1), 4'(k % 16), p[4*k], p[4*k+1], p[4*k+2], p[4*k+3]});
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
    int cyc;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    in_bytes = nb;
    cyc = 0;
    while (!in_ready && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("in_handshake_timeout", 64'(cyc >= 500), 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Invalid lanes and in_bytes of non-last words are randomised; a full last word uses 4..7.
  task automatic send_words(input logic [7:0] m[$]);
    logic [31:0] d;
    logic        last;
    logic [2:0]  nb;
    int          n;
    if (m.size() == 0) begin
      send_word(32'hDEADBEEF, 1'b1, 3'd0);
    end else begin
      for (int i = 0; i < m.size(); i += 4) begin
        n = (m.size() - i < 4) ? m.size() - i : 4;
        d = $urandom();
        for (int b = 0; b < n; b++) d[31-8*b -: 8] = m[i+b];
        last = (i + 4 >= m.size());
        if (last) nb = (n == 4) ? 3'($urandom_range(4, 7)) : 3'(n);
        else      nb = 3'($urandom_range(0, 7));
        send_word(d, last, nb);
      end
    end
  endtask

  task automatic send_msg(input logic [7:0] m[$]);
    build_exp(m);
    send_words(m);
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check("drain_pending", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic monitor();
    logic [36:0] e;
    forever begin
      @(negedge clk);
      if (reset_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $error("FAIL unexpected_output: observed idx %0d word %0h expected no word", out_idx, out_word);
        end else begin
          e = exp_q.pop_front();
          check("out_word", 64'(out_word), 64'(e[31:0]));
          check("out_idx", 64'(out_idx), 64'(e[35:32]));
          check("out_msg_end", 64'(out_msg_end), 64'(e[36]));
        end
      end
    end
  endtask

  task automatic drive_ready();
    forever begin
      @(posedge clk);
      #2;
      out_ready = force_stall ? 1'b0 : (rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  endtask

  logic [7:0] msg[$];

  initial begin
    n_chk = 0;
    n_fail = 0;
    force_stall = 1'b0;
    rand_bp = 1'b0;
    reset_n = 1'b0;
    in_valid = 1'b0;
    in_data = 32'h0;
    in_last = 1'b0;
    in_bytes = 3'd0;
    out_ready = 1'b1;
    fork
      monitor();
      drive_ready();
      begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_word", 64'(out_word), 64'd0);
    check("rst_out_idx", 64'(out_idx), 64'd0);
    check("rst_msg_end", 64'(out_msg_end), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    msg = '{8'h61, 8'h62, 8'h63};
    send_msg(msg);
    drain();

    msg = {};
    send_msg(msg);
    drain();

    msg = {};
    for (int i = 0; i < 55; i++) msg.push_back(8'($urandom()));
    send_msg(msg);
    drain();

    msg = {};
    for (int i = 0; i < 56; i++) msg.push_back(8'($urandom()));
    send_msg(msg);
    drain();

    rand_bp = 1'b1;
    for (int r = 0; r < 5; r++) begin
      msg = {};
      for (int i = 0; i < int'($urandom_range(1, 140)); i++) msg.push_back(8'($urandom()));
      send_msg(msg);
    end
    msg = {};
    for (int i = 0; i < 64; i++) msg.push_back(8'($urandom()));
    send_msg(msg);
    drain();
    rand_bp = 1'b0;

    // Hold the output during zero fill and confirm the held word and idle input.
    msg = '{8'h61, 8'h62, 8'h63};
    send_msg(msg);
    begin
      int cyc;
      cyc = 0;
      while (!(dbg_state == 3'd2 && out_valid) && cyc < 50) begin
        @(negedge clk);
        cyc++;
      end
      force_stall = 1'b1;
      while (out_ready && cyc < 100) begin
        @(negedge clk);
        cyc++;
      end
      check("stall_reach_timeout", 64'(cyc >= 100), 64'd0);
      for (int k = 0; k < 5; k++) begin
        check("stall_out_valid", 64'(out_valid), 64'd1);
        check("stall_out_word", 64'(out_word), 64'(exp_q[0][31:0]));
        check("stall_out_idx", 64'(out_idx), 64'(exp_q[0][35:32]));
        check("stall_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
      end
      force_stall = 1'b0;
    end
    drain();

    rand_bp = 1'b1;
    for (int k = 0; k < 7; k++) begin
      logic [31:0] w;
      w = $urandom();
      exp_q.push_back({1'b0, 4'(k), w});
      send_word(w, 1'b0, 3'($urandom_range(0, 7)));
    end
    drain();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out_idx", 64'(out_idx), 64'd0);
    check("mid_rst_out_word", 64'(out_word), 64'd0);
    check("mid_rst_state", 64'(dbg_state), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rand_bp = 1'b0;
    @(negedge clk);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    msg = '{8'h61, 8'h62, 8'h63};
    send_msg(msg);
    drain();

`ifdef SHA256_PAD_OVF_EN
    msg = {};
    for (int i = 0; i < 8192; i++) msg.push_back(8'(i));
    send_msg(msg);
    begin
      int cyc;
      cyc = 0;
      while (!(out_valid && out_msg_end) && cyc < 100) begin
        @(negedge clk);
        cyc++;
      end
      check("ovf_end_timeout", 64'(cyc >= 100), 64'd0);
      check("len_ovf_set", 64'(len_ovf), 64'd1);
    end
    drain();
`endif

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sha256_padder.md
SHA256_PADDER -- requirements
Module: sha256_padder

Interface
REQ-001 LEN_W, default 32, width of the internal message bit-length counter (legal 16..64); the counter is zero-extended to 64 bits in the length field.
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 in_valid  in  1  a message word is present.
REQ-005 in_ready  out  1  padder accepts in_data this cycle.
REQ-006 in_data  in  32  message word, big-endian; byte 0 is [31:24].
REQ-007 in_last  in  1  this word is the final word of the message.
REQ-008 in_bytes  in  3  valid bytes in the in_last word, 0..4, MSB-aligned; values 5..7 are treated as 4 and ignored when in_last=0.
REQ-009 out_valid  out  1  padded word available.
REQ-010 out_ready  in  1  downstream compression core accepts out_word.
REQ-011 out_word  out  32  padded message word W[out_idx].
REQ-012 out_idx  out  4  index of out_word within its 512-bit block.
REQ-013 out_msg_end  out  1  high with word 15 of the final block of a message only.
REQ-014 len_ovf  out  1  sticky length-overflow flag; port present only under SHA256_PAD_OVF_EN.

Function
REQ-015 The output SHALL be a single registered stage: in_ready = (state==DATA) && (!out_valid || out_ready), giving 1-cycle latency from input handshake to out_valid.
REQ-016 out_word, out_idx and out_msg_end SHALL hold stable while out_valid && !out_ready.
REQ-017 out_idx SHALL increment modulo 16 on each output handshake and reset to 0 after out_msg_end is transferred.
REQ-018 States: DATA, PAD80, ZERO, LEN_HI, LEN_LO.
REQ-019 In DATA, a non-last accepted word SHALL be output unchanged, and the bit counter SHALL add 32.
REQ-020 When the last word is accepted with in_bytes=n<4, the padder SHALL output the n valid bytes, then 0x80 in byte n, then zeros (invalid lanes ignored), and the counter SHALL add 8n; n=0 yields 0x80000000.
REQ-021 When the last word is accepted with in_bytes=4, the word SHALL be output unchanged and the state SHALL go to PAD80, which emits 0x80000000 as the next word.
REQ-022 Let p be the index of the word holding the 0x80 byte: if p<=13, the padder SHALL output ZERO words through idx 13 followed by LEN_HI at idx 14 and LEN_LO at idx 15.
REQ-023 If p>=14, the padder SHALL output zeros through idx 15, then a second block with zeros at idx 0..13 and the length at idx 14..15.
REQ-024 LEN_HI SHALL be bits [63:32] of the zero-extended bit count and LEN_LO SHALL be bits [31:0].
REQ-025 After LEN_LO is transferred, the padder SHALL clear the counter and return to DATA.
REQ-026 The bit counter SHALL wrap modulo 2^LEN_W.
REQ-027 The input SHALL be stalled (in_ready=0) in every state except DATA.

Reset
REQ-028 While reset_n=0, the block SHALL hold: state=DATA, out_valid=0, out_word=0, out_idx=0, out_msg_end=0, bit counter=0, len_ovf=0; in_ready=1 after release.
REQ-029 Reset asserted mid-message or mid-padding SHALL discard all partial state, and the next accepted word SHALL start a new message at idx 0.

Configuration
REQ-030 With SHA256_PAD_OVF_EN defined, len_ovf SHALL set when a counter addition carries out of bit LEN_W-1, remain set through the message, and clear on the first input handshake of the next message.
REQ-031 Without SHA256_PAD_OVF_EN, the len_ovf port and its logic SHALL be absent and the counter SHALL wrap silently.

Verification
REQ-032 Case "abc": in_data=0x61626300, in_bytes=3, last -> 0x61626380, idx1..14=0, idx15=0x00000018 with out_msg_end.
REQ-033 Case empty message: in_data=0xDEADBEEF, in_bytes=0, last -> 0x80000000, then zeros, idx15=0x00000000 with out_msg_end.
REQ-034 Case 55 bytes: 13 full words + 3-byte last -> single block, 0x80 in word 13 byte 3, idx14=0, idx15=0x000001B8.
REQ-035 Case 56 bytes: 14 full words -> block 1 idx14=0x80000000, idx15=0; block 2 idx0..14=0, idx15=0x000001C0; out_msg_end only on block 2 idx15.
REQ-036 Case backpressure: out_ready=0 for 5 cycles during ZERO -> out_word/out_idx stable, in_ready=0, no words lost or duplicated.
REQ-037 Case reset mid-block (after 7 words) then "abc" -> output identical to REQ-032; with SHA256_PAD_OVF_EN and LEN_W=16, 8192 bytes -> len_ovf=1, LEN_LO=0.
